// File: rtl/gate_unit_pipe_if.sv
// Handshake bundle for gate_unit_pipe: producer side (op/a/b) and consumer side (y).
// y_parity exists only when GATE_UNIT_PARITY_EN is defined.
interface gate_unit_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] op_count;
`ifdef GATE_UNIT_PARITY_EN
  logic             y_parity;

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, op_count, y_parity
  );

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, op_count, y_parity
  );
`else
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, op_count
  );

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, op_count
  );
`endif
endinterface

// File: rtl/gate_unit_pipe.sv
// Registered WIDTH-bit gate unit feeding a 2-entry FIFO output buffer with valid/ready.
// Optional GATE_UNIT_PARITY_EN stores ^result per entry and drives y_parity from the head.
module gate_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  gate_unit_pipe_if.slave bus
);

`ifdef GATE_UNIT_PARITY_EN
  localparam int unsigned EntryW = WIDTH + 1;
`else
  localparam int unsigned EntryW = WIDTH;
`endif

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e              state_q;
  logic [EntryW-1:0]   head_q;
  logic [EntryW-1:0]   tail_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [CNT_W-1:0]    count_q;

  logic [WIDTH-1:0]    result;
  logic [EntryW-1:0]   entry;
  logic                accept;
  logic                pop;

  assign accept = bus.in_valid & in_ready_q;
  assign pop    = out_valid_q & bus.out_ready;

  // Ops 0 and 7 only look at a, so b (even X) cannot reach the result.
  always_comb begin
    result = '0;
    unique case (bus.op)
      3'd0: result = ~bus.a;
      3'd1: result = bus.a & bus.b;
      3'd2: result = bus.a | bus.b;
      3'd3: result = bus.a ^ bus.b;
      3'd4: result = ~(bus.a & bus.b);
      3'd5: result = ~(bus.a | bus.b);
      3'd6: result = ~(bus.a ^ bus.b);
      3'd7: result = bus.a;
    endcase
  end

`ifdef GATE_UNIT_PARITY_EN
  assign entry = {^result, result};
`else
  assign entry = result;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      if (accept) begin
        count_q <= count_q + 1'b1;
      end
      case (state_q)
        StEmpty: begin
          if (accept) begin
            head_q      <= entry;
            state_q     <= StOne;
            out_valid_q <= 1'b1;
          end
        end
        StOne: begin
          if (accept && !pop) begin
            tail_q     <= entry;
            state_q    <= StTwo;
            in_ready_q <= 1'b0;
          end else if (pop && !accept) begin
            // Clear the head so y and y_parity read 0 while empty.
            head_q      <= '0;
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
          end else if (accept && pop) begin
            head_q <= entry;
          end
        end
        StTwo: begin
          if (pop) begin
            head_q     <= tail_q;
            tail_q     <= '0;
            state_q    <= StOne;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= StEmpty;
          head_q      <= '0;
          tail_q      <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = head_q[WIDTH-1:0];
  assign bus.op_count  = count_q;
`ifdef GATE_UNIT_PARITY_EN
  assign bus.y_parity  = head_q[WIDTH];
`endif

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Directed self-checking bench for gate_unit_pipe (WIDTH=8, CNT_W=4 so the counter wrap is reachable).
module tb_gate_unit_pipe;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [CNT_W-1:0] exp_cnt;

  gate_unit_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  gate_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are then read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_cnt = '0;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.y !== 8'h00) $display("FAIL reset_y: got %h want 00", bus.y);
    else n_pass++;
    n_checks++;
    if (bus.op_count !== 4'd0) $display("FAIL reset_op_count: got %0d want 0", bus.op_count);
    else n_pass++;
`ifdef GATE_UNIT_PARITY_EN
    n_checks++;
    if (bus.y_parity !== 1'b0) $display("FAIL reset_y_parity: got %b want 0", bus.y_parity);
    else n_pass++;
`endif
  endtask

  task automatic test_not();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = 3'd0;
    bus.a         = 8'hA5;
    bus.b         = 'x;
    step();
    exp_cnt++;
    bus.in_valid = 1'b0;
    bus.b        = '0;
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL not_out_valid: got %b want 1", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.y !== 8'h5A) $display("FAIL not_y: got %h want 5a", bus.y);
    else n_pass++;
    n_checks++;
    if (bus.op_count !== 4'd1) $display("FAIL not_op_count: got %0d want 1", bus.op_count);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL not_drained: got %b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_ops();
    logic [7:0] exp_y [1:6];
    exp_y[1] = 8'h30;
    exp_y[2] = 8'hFC;
    exp_y[3] = 8'hCC;
    exp_y[4] = 8'hCF;
    exp_y[5] = 8'h03;
    exp_y[6] = 8'h33;
    bus.out_ready = 1'b1;
    bus.a         = 8'hF0;
    bus.b         = 8'h3C;
    for (int i = 1; i <= 6; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = 3'(i);
      step();
      exp_cnt++;
      n_checks++;
      if (bus.y !== exp_y[i] || bus.out_valid !== 1'b1)
        $display("FAIL ops_y op=%0d: got %h/%b want %h/1", i, bus.y, bus.out_valid, exp_y[i]);
      else n_pass++;
    end
    bus.in_valid = 1'b0;
    step();
    n_checks++;
    if (bus.op_count !== exp_cnt) $display("FAIL ops_op_count: got %0d want %0d", bus.op_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 3'd7;
    bus.b         = 'x;
    bus.a         = 8'h01;
    step();
    exp_cnt++;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_one: got %b want 1", bus.in_ready);
    else n_pass++;
    bus.a = 8'h02;
    step();
    exp_cnt++;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_two: got %b want 0", bus.in_ready);
    else n_pass++;
    bus.a = 8'h03;
    step();
    n_checks++;
    if (bus.y !== 8'h01 || bus.in_ready !== 1'b0)
      $display("FAIL bp_hold: got y=%h ready=%b want y=01 ready=0", bus.y, bus.in_ready);
    else n_pass++;
    n_checks++;
    if (bus.op_count !== exp_cnt) $display("FAIL bp_op_count: got %0d want %0d", bus.op_count, exp_cnt);
    else n_pass++;
    bus.in_valid  = 1'b0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    step();
    n_checks++;
    if (bus.y !== 8'h02 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1)
      $display("FAIL bp_pop1: got y=%h v=%b r=%b want 02/1/1", bus.y, bus.out_valid, bus.in_ready);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_pop2: got %b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_accept_pop();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 3'd3;
    bus.a         = 8'h0F;
    bus.b         = 8'hFF;
    step();
    exp_cnt++;
    n_checks++;
    if (bus.y !== 8'hF0) $display("FAIL ap_first: got %h want f0", bus.y);
    else n_pass++;
    bus.out_ready = 1'b1;
    bus.op        = 3'd1;
    bus.a         = 8'hAA;
    bus.b         = 8'h0F;
    step();
    exp_cnt++;
    n_checks++;
    if (bus.y !== 8'h0A || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1)
      $display("FAIL ap_swap: got y=%h r=%b v=%b want 0a/1/1", bus.y, bus.in_ready, bus.out_valid);
    else n_pass++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.y !== 8'h0A || bus.out_valid !== 1'b1)
      $display("FAIL ap_stable: got y=%h v=%b want 0a/1", bus.y, bus.out_valid);
    else n_pass++;
    bus.out_ready = 1'b1;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL ap_no_dup: got %b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 3'd7;
    bus.a         = 8'h11;
    step();
    bus.a = 8'h22;
    step();
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL rm_full: got %b want 0", bus.in_ready);
    else n_pass++;
    rst   = 1'b1;
    bus.a = 8'h33;
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    exp_cnt      = '0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL rm_flags: got v=%b r=%b want 0/1", bus.out_valid, bus.in_ready);
    else n_pass++;
    n_checks++;
    if (bus.op_count !== 4'd0 || bus.y !== 8'h00)
      $display("FAIL rm_clear: got cnt=%0d y=%h want 0/00", bus.op_count, bus.y);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL rm_stays_empty: got %b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = 3'd7;
    bus.a         = 8'h07;
    for (int i = 0; i < 17; i++) begin
      step();
      exp_cnt++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.op_count !== 4'd1) $display("FAIL wrap_op_count: got %0d want 1", bus.op_count);
    else n_pass++;
    n_checks++;
    if (bus.y !== 8'h07) $display("FAIL wrap_y: got %h want 07", bus.y);
    else n_pass++;
`ifdef GATE_UNIT_PARITY_EN
    n_checks++;
    if (bus.y_parity !== 1'b1) $display("FAIL parity_head: got %b want 1", bus.y_parity);
    else n_pass++;
`endif
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.op_count !== exp_cnt)
      $display("FAIL wrap_drain: got v=%b cnt=%0d want 0/%0d", bus.out_valid, bus.op_count, exp_cnt);
    else n_pass++;
`ifdef GATE_UNIT_PARITY_EN
    n_checks++;
    if (bus.y_parity !== 1'b0) $display("FAIL parity_empty: got %b want 0", bus.y_parity);
    else n_pass++;
`endif
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_cnt  = '0;
    test_reset();
    test_not();
    test_ops();
    test_backpressure();
    test_accept_pop();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
